stopwatch_lap: RTL and testbench
================================

# stopwatch_lap

Parametrised lap stopwatch that succeeds the single-channel start/stop stopwatch in the pseudo-terminal datapath. It counts minutes/seconds/hundredths from `clk` through an internal prescaler and is controlled by a `go` pulse or decoded terminal op codes (start/stop, lap, clear). It buffers lap captures in a small FIFO that the terminal display logic drains. All control is edge- and strobe-qualified; there is no level-toggle behaviour.

## Interface
- `CLK_HZ`, 100_000_000: input clock frequency.
- `TICK_HZ`, 100: hundredths rate; `DIV = CLK_HZ/TICK_HZ`, must be ≥ 2 and an exact integer.
- `MAX_MIN`, 100: minutes modulus, 1..1023.
- `LAP_DEPTH`, 8: lap FIFO entries, power of two, ≥ 2.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: one clock; reset is asynchronous and active-low.
- `go` input 1: synchronous to `clk`; a rising edge requests start/stop.
- `op_valid` input 1: qualifies `op_code` for one cycle.
- `op_code` input 11: terminal command.
- `minutes`, `seconds`, `hundreth_sec` output 10 each: binary time values.
- `running` output 1: high in RUN.
- `rollover` output 1: sticky; set when minutes wrap.
- `lap_valid` output 1: FIFO not empty.
- `lap_rd` input 1: pops the head when `lap_valid` is high; ignored otherwise.
- `lap_time` output 30: head entry `{minutes, seconds, hundreth_sec}`, first-word fall-through.
- `lap_ovf` output 1: sticky; a lap was dropped because the FIFO was full.

## Operation
- Op codes: OP_STARTSTOP = 11'b00001000000, OP_LAP = 11'b00010000000, OP_CLEAR = 11'b00100000000. Any other code with `op_valid` is ignored.
- `ss_evt` = (`go` & ~`go_q`) | (`op_valid` & OP_STARTSTOP). A go edge and the op code in the same cycle produce one toggle.
- States: IDLE (count zero, stopped), RUN, PAUSED.
  - IDLE and PAUSED go to RUN on `ss_evt`.
  - RUN goes to PAUSED on `ss_evt`.
  - Any state goes to IDLE on OP_CLEAR.
  - OP_CLEAR wins over `ss_evt` in the same cycle.
- OP_CLEAR zeros the time, the prescaler, `rollover` and `lap_ovf`, and flushes the FIFO.
- Prescaler counts 0..DIV-1 only in RUN and holds its residue in PAUSED. A tick occurs when it wraps.
- On a tick:
  - hundredths increment, wrapping 99→0 with a carry to seconds;
  - seconds wrap 59→0 with a carry to minutes;
  - minutes wrap MAX_MIN-1→0, which sets `rollover`.
- OP_LAP is accepted in RUN only and is ignored in IDLE and PAUSED. It pushes the time visible on the outputs during the op cycle.
- If the FIFO is full on a push, the entry is dropped and `lap_ovf` is set. This applies unless `lap_rd` pops in the same cycle; then the push and the pop both happen and there is no overflow.

## Timing
- Reset values: state IDLE; all time outputs 0; `running`, `rollover`, `lap_valid`, `lap_ovf` at 0; `lap_time` 0; `go_q` 0; prescaler 0.
- `running` rises one cycle after the `ss_evt` cycle. The first tick occurs DIV cycles after `running` rises from IDLE.
- Time outputs update on the edge where the prescaler wraps, with registered outputs and no extra latency.
- `lap_valid` rises one cycle after the push cycle. After a pop, `lap_time` shows the next entry in the following cycle.
- Asserting `reset_n` low mid-count returns every output to its reset value immediately; the first post-reset edge sees IDLE.

## Configuration
- `STOPWATCH_LAP_EN` defined: the lap FIFO, OP_LAP, `lap_*` and `lap_ovf` are functional.
- Not defined: there is no FIFO storage; OP_LAP is ignored; `lap_valid`, `lap_time` and `lap_ovf` are tied to 0; `lap_rd` is unused. Ports are unchanged.

## Structure
- Package `stopwatch_pkg`: op code constants, the state enum (IDLE/RUN/PAUSED), `TIME_W = 10`, and `LAP_W = 30`.
- Sub-module `lap_fifo`: synchronous FWFT FIFO with parameters `WIDTH` and `DEPTH`, ports push/pop/full/empty/dout, and a flush input. Control, prescaler and time counters stay in `stopwatch_lap`.

## Test plan
Simulations use CLK_HZ=1000 and TICK_HZ=100 (DIV=10).
- Reset, then a go pulse at cycle 5 → `running`=1 at cycle 6; `hundreth_sec`=1 at cycle 16; after 1000 running cycles the time is 00:01.00.
- Start, run 125 cycles, OP_STARTSTOP, wait 50 cycles, restart → time is frozen at 00:00.12 while paused; the next tick arrives after the 5-cycle residue.
- MAX_MIN=2, run to 01:59.99 then one more tick → time 00:00.00 and `rollover`=1; OP_CLEAR → `rollover`=0 and state IDLE.
- LAP_DEPTH=2, RUN, three OP_LAPs at 00:00.03, 00:00.07 and 00:00.09 → `lap_ovf`=1; pops return 3 then 7; then `lap_valid`=0.
- Go rising edge and `op_valid` OP_STARTSTOP in the same cycle → exactly one toggle. OP_CLEAR together with OP_STARTSTOP → IDLE with `running`=0.
- `reset_n` pulsed low mid-run at 00:00.42 → all outputs 0 asynchronously; the FIFO is empty after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the lap stopwatch: terminal op codes,
// control FSM states and field widths.
package stopwatch_pkg;

    localparam int unsigned TIME_W = 10;
    localparam int unsigned LAP_W  = 3 * TIME_W;

    localparam logic [10:0] OP_STARTSTOP = 11'b00001000000;
    localparam logic [10:0] OP_LAP       = 11'b00010000000;
    localparam logic [10:0] OP_CLEAR     = 11'b00100000000;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused
    } sw_state_e;

endpackage

// File: rtl/lap_fifo.sv
// First-word fall-through FIFO holding lap captures. A push into a full FIFO is
// accepted only when a pop frees the head in the same cycle; flush empties it.
module lap_fifo #(
    parameter int unsigned WIDTH = 30,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    assign pop_ok  = pop & ~empty & ~flush;
    assign push_ok = push & (~full | pop_ok) & ~flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q[AW-1:0]] = din;
                wr_ptr_d                = wr_ptr_q + (AW + 1)'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/stopwatch_lap.sv
// Lap stopwatch: prescaled mm:ss.hh counter with start/stop/clear control and an
// optional lap capture FIFO, enabled by defining STOPWATCH_LAP_EN.
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int unsigned MAX_MIN   = 100,
    parameter int unsigned LAP_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              go,
    input  logic              op_valid,
    input  logic [10:0]       op_code,
    output logic [TIME_W-1:0] minutes,
    output logic [TIME_W-1:0] seconds,
    output logic [TIME_W-1:0] hundreth_sec,
    output logic              running,
    output logic              rollover,
    output logic              lap_valid,
    input  logic              lap_rd,
    output logic [LAP_W-1:0]  lap_time,
    output logic              lap_ovf
);

    localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
    localparam int unsigned PS_W = (DIV > 1) ? $clog2(DIV) : 1;

    sw_state_e         state_q, state_d;
    logic              go_q, go_d;
    logic [PS_W-1:0]   ps_q, ps_d;
    logic [TIME_W-1:0] min_q, min_d, sec_q, sec_d, hs_q, hs_d;
    logic              rollover_q, rollover_d;
    logic              ss_evt, clr, lap_req, tick;

    assign ss_evt  = (go & ~go_q) | (op_valid & (op_code == OP_STARTSTOP));
    assign clr     = op_valid & (op_code == OP_CLEAR);
    assign lap_req = op_valid & (op_code == OP_LAP) & (state_q == StRun);

    always_comb begin
        state_d    = state_q;
        go_d       = go;
        ps_d       = ps_q;
        min_d      = min_q;
        sec_d      = sec_q;
        hs_d       = hs_q;
        rollover_d = rollover_q;
        tick       = 1'b0;
        if (clr) begin
            state_d    = StIdle;
            ps_d       = '0;
            min_d      = '0;
            sec_d      = '0;
            hs_d       = '0;
            rollover_d = 1'b0;
        end else begin
            if (state_q == StRun) begin
                if (ps_q == PS_W'(DIV - 1)) begin
                    ps_d = '0;
                    tick = 1'b1;
                end else begin
                    ps_d = ps_q + PS_W'(1);
                end
            end
            if (tick) begin
                if (hs_q == TIME_W'(99)) begin
                    hs_d = '0;
                    if (sec_q == TIME_W'(59)) begin
                        sec_d = '0;
                        if (min_q == TIME_W'(MAX_MIN - 1)) begin
                            min_d      = '0;
                            rollover_d = 1'b1;
                        end else begin
                            min_d = min_q + TIME_W'(1);
                        end
                    end else begin
                        sec_d = sec_q + TIME_W'(1);
                    end
                end else begin
                    hs_d = hs_q + TIME_W'(1);
                end
            end
            if (ss_evt) begin
                state_d = (state_q == StRun) ? StPaused : StRun;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            go_q       <= 1'b0;
            ps_q       <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            hs_q       <= '0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            go_q       <= go_d;
            ps_q       <= ps_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            hs_q       <= hs_d;
            rollover_q <= rollover_d;
        end
    end

    assign minutes      = min_q;
    assign seconds      = sec_q;
    assign hundreth_sec = hs_q;
    assign running      = (state_q == StRun);
    assign rollover     = rollover_q;

`ifdef STOPWATCH_LAP_EN
    logic fifo_full, fifo_empty, lap_pop, lap_drop;
    logic lap_ovf_q, lap_ovf_d;

    assign lap_pop  = lap_rd & ~fifo_empty;
    // A pop in the same cycle makes room, so only an unrelieved full push drops.
    assign lap_drop = lap_req & fifo_full & ~lap_pop;

    lap_fifo #(
        .WIDTH(LAP_W),
        .DEPTH(LAP_DEPTH)
    ) u_lap_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .flush  (clr),
        .push   (lap_req),
        .pop    (lap_pop),
        .din    ({min_q, sec_q, hs_q}),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .dout   (lap_time)
    );

    always_comb begin
        lap_ovf_d = lap_ovf_q;
        if (clr) begin
            lap_ovf_d = 1'b0;
        end else if (lap_drop) begin
            lap_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lap_ovf_q <= 1'b0;
        end else begin
            lap_ovf_q <= lap_ovf_d;
        end
    end

    assign lap_valid = ~fifo_empty;
    assign lap_ovf   = lap_ovf_q;
`else
    localparam int unsigned lap_depth_unused = LAP_DEPTH;
    logic lap_unused;

    assign lap_unused = lap_rd ^ lap_req;
    assign lap_valid  = 1'b0;
    assign lap_time   = '0;
    assign lap_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_lap.sv
// Self-checking bench for stopwatch_lap: directed scenarios plus randomized
// traffic against a tick-count reference model (honours STOPWATCH_LAP_EN).
module tb_stopwatch_lap;

    localparam int DIV1    = 10;
    localparam int DIV2    = 2;
    localparam int MAX_MIN = 2;
    localparam int DEPTH   = 2;
    localparam logic [10:0] OP_SS  = 11'b00001000000;
    localparam logic [10:0] OP_LAP = 11'b00010000000;
    localparam logic [10:0] OP_CLR = 11'b00100000000;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        clk = 1'b0, reset_n = 1'b0, go = 1'b0, op_valid = 1'b0, lap_rd = 1'b0;
    logic [10:0] op_code = '0;
    logic [9:0]  minutes, seconds, hs, minutes2, seconds2, hs2;
    logic        running, rollover, lap_valid, lap_ovf;
    logic        running2, rollover2, lap_valid2, lap_ovf2;
    logic [29:0] lap_time, lap_time2;

    int tests_run = 0, tests_failed = 0;

    // Reference model: state (0 idle, 1 run, 2 paused), count of clocks spent in RUN,
    // lap queue and overflow flag. Time is derived arithmetically from run clocks.
    int          m_state = 0, m_run = 0;
    bit          m_goq = 0, m_ovf = 0;
    logic [29:0] m_q[$];

    stopwatch_lap #(.CLK_HZ(1000), .TICK_HZ(100), .MAX_MIN(MAX_MIN), .LAP_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .go(go), .op_valid(op_valid), .op_code(op_code),
        .minutes(minutes), .seconds(seconds), .hundreth_sec(hs), .running(running),
        .rollover(rollover), .lap_valid(lap_valid), .lap_rd(lap_rd), .lap_time(lap_time),
        .lap_ovf(lap_ovf)
    );

    stopwatch_lap #(.CLK_HZ(200), .TICK_HZ(100), .MAX_MIN(MAX_MIN), .LAP_DEPTH(DEPTH)) dut2 (
        .clk(clk), .reset_n(reset_n), .go(go), .op_valid(op_valid), .op_code(op_code),
        .minutes(minutes2), .seconds(seconds2), .hundreth_sec(hs2), .running(running2),
        .rollover(rollover2), .lap_valid(lap_valid2), .lap_rd(lap_rd), .lap_time(lap_time2),
        .lap_ovf(lap_ovf2)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] mtime(int run, int div);
        int t;
        t = (run / div) % (MAX_MIN * 6000);
        return {10'(t / 6000), 10'((t / 100) % 60), 10'(t % 100)};
    endfunction

    function automatic logic mroll(int run, int div);
        return (run / div) >= (MAX_MIN * 6000);
    endfunction

    function automatic logic [63:0] mexp();
        logic [29:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 30'd0;
        return {mtime(m_run, DIV1), m_state == 1, mroll(m_run, DIV1), m_q.size() > 0,
                head, m_ovf};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_run   = 0;
        m_goq   = 0;
        m_ovf   = 0;
        m_q.delete();
    endtask

    task automatic model_step();
        bit ss, clr, lap, pop, full;
        logic [29:0] now;
        ss  = (go && !m_goq) || (op_valid && op_code == OP_SS);
        clr = op_valid && op_code == OP_CLR;
        lap = LAP_EN && op_valid && op_code == OP_LAP && m_state == 1;
        pop = LAP_EN && lap_rd && m_q.size() > 0;
        now = mtime(m_run, DIV1);
        m_goq = go;
        if (clr) begin
            m_state = 0;
            m_run   = 0;
            m_ovf   = 0;
            m_q.delete();
        end else begin
            full = (m_q.size() == DEPTH);
            if (pop) void'(m_q.pop_front());
            if (lap) begin
                if (!full || pop) m_q.push_back(now);
                else m_ovf = 1;
            end
            if (m_state == 1) m_run++;
            if (ss) m_state = (m_state == 1) ? 2 : 1;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [10:0] code);
        op_valid = 1'b1;
        op_code  = code;
        cycle();
        op_valid = 1'b0;
        op_code  = '0;
    endtask

    task automatic start_go();
        go = 1'b1;
        cycle();
        go = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tests_run++;
        if ({minutes, seconds, hs, running, rollover, lap_valid, lap_time, lap_ovf} !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %h expected 0",
                     {minutes, seconds, hs, running, rollover, lap_valid, lap_time, lap_ovf});
        end
        repeat (5) cycle();
    endtask

    task automatic test_go_timing();
        start_go();
        tests_run++;
        if (running !== 1'b1) begin
            tests_failed++;
            $display("FAIL go_running: running=%b expected 1", running);
        end
        repeat (9) cycle();
        tests_run++;
        if (hs !== 10'd0) begin
            tests_failed++;
            $display("FAIL pre_tick: hundreth_sec=%0d expected 0", hs);
        end
        cycle();
        tests_run++;
        if (hs !== 10'd1) begin
            tests_failed++;
            $display("FAIL first_tick: hundreth_sec=%0d expected 1", hs);
        end
        repeat (990) cycle();
        tests_run++;
        if ({minutes, seconds, hs} !== {10'd0, 10'd1, 10'd0}) begin
            tests_failed++;
            $display("FAIL one_second: got %0d:%0d.%0d expected 0:1.0", minutes, seconds, hs);
        end
        op(OP_SS);
        tests_run++;
        if (running !== 1'b0) begin
            tests_failed++;
            $display("FAIL stop: running=%b expected 0", running);
        end
    endtask

    task automatic test_pause();
        op(OP_CLR);
        start_go();
        repeat (124) cycle();
        op(OP_SS);
        tests_run++;
        if ({running, minutes, seconds, hs} !== {1'b0, 10'd0, 10'd0, 10'd12}) begin
            tests_failed++;
            $display("FAIL pause_time: run=%b %0d:%0d.%0d expected 0 0:0.12",
                     running, minutes, seconds, hs);
        end
        repeat (50) cycle();
        tests_run++;
        if (hs !== 10'd12) begin
            tests_failed++;
            $display("FAIL pause_frozen: hundreth_sec=%0d expected 12", hs);
        end
        start_go();
        repeat (4) cycle();
        tests_run++;
        if (hs !== 10'd12) begin
            tests_failed++;
            $display("FAIL residue_early: hundreth_sec=%0d expected 12", hs);
        end
        cycle();
        tests_run++;
        if (hs !== 10'd13) begin
            tests_failed++;
            $display("FAIL residue_tick: hundreth_sec=%0d expected 13", hs);
        end
    endtask

    task automatic test_lap();
        op(OP_CLR);
        start_go();
        repeat (30) cycle();
        op(OP_LAP);
        repeat (39) cycle();
        op(OP_LAP);
        repeat (19) cycle();
        op(OP_LAP);
        tests_run++;
        if ({lap_ovf, lap_valid, lap_time} !== {LAP_EN, LAP_EN, LAP_EN ? 30'd3 : 30'd0}) begin
            tests_failed++;
            $display("FAIL lap_full: ovf=%b valid=%b time=%0d", lap_ovf, lap_valid, lap_time);
        end
        lap_rd = 1'b1;
        cycle();
        lap_rd = 1'b0;
        tests_run++;
        if ({lap_valid, lap_time} !== {LAP_EN, LAP_EN ? 30'd7 : 30'd0}) begin
            tests_failed++;
            $display("FAIL lap_pop1: valid=%b time=%0d", lap_valid, lap_time);
        end
        lap_rd = 1'b1;
        cycle();
        lap_rd = 1'b0;
        tests_run++;
        if (lap_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL lap_drain: lap_valid=%b expected 0", lap_valid);
        end
        op(OP_SS);
        op(OP_LAP);
        cycle();
        tests_run++;
        if (lap_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL lap_paused: lap_valid=%b expected 0", lap_valid);
        end
    endtask

    task automatic test_simultaneous();
        op(OP_CLR);
        go = 1'b1;
        op(OP_SS);
        tests_run++;
        if (running !== 1'b1) begin
            tests_failed++;
            $display("FAIL dual_start: running=%b expected 1", running);
        end
        go = 1'b0;
        repeat (3) cycle();
        go = 1'b1;
        op(OP_CLR);
        go = 1'b0;
        tests_run++;
        if ({running, minutes, seconds, hs} !== 31'd0) begin
            tests_failed++;
            $display("FAIL clear_wins: running=%b time=%0d:%0d.%0d expected idle zero",
                     running, minutes, seconds, hs);
        end
    endtask

    task automatic test_rollover();
        int n;
        op(OP_CLR);
        start_go();
        n = 0;
        while (!(minutes2 == 10'd1 && seconds2 == 10'd59 && hs2 == 10'd99) && n < 30000) begin
            cycle();
            n++;
        end
        tests_run++;
        if (n >= 30000 || rollover2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reach_max: %0d:%0d.%0d rollover=%b after %0d cycles",
                     minutes2, seconds2, hs2, rollover2, n);
        end
        n = 0;
        while (hs2 == 10'd99 && n < 10) begin
            cycle();
            n++;
        end
        tests_run++;
        if ({minutes2, seconds2, hs2, rollover2} !== {mtime(m_run, DIV2), mroll(m_run, DIV2)} ||
            {minutes2, seconds2, hs2, rollover2} !== {30'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL rollover_wrap: %0d:%0d.%0d rollover=%b expected 0:0.0 rollover=1",
                     minutes2, seconds2, hs2, rollover2);
        end
        tests_run++;
        if ({minutes, seconds, hs, rollover} !== {mtime(m_run, DIV1), mroll(m_run, DIV1)}) begin
            tests_failed++;
            $display("FAIL slow_track: %0d:%0d.%0d expected %h", minutes, seconds, hs,
                     mtime(m_run, DIV1));
        end
        op(OP_CLR);
        tests_run++;
        if ({rollover2, running2, minutes2, seconds2, hs2} !== 32'd0) begin
            tests_failed++;
            $display("FAIL rollover_clear: rollover=%b running=%b expected 0 0", rollover2, running2);
        end
    endtask

    task automatic test_random();
        int r;
        logic [63:0] got;
        for (int i = 0; i < 800; i++) begin
            go       = ($urandom_range(0, 7) == 0);
            lap_rd   = ($urandom_range(0, 3) == 0);
            op_valid = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 19);
            if (r < 2)       op_code = OP_SS;
            else if (r < 9)  op_code = OP_LAP;
            else if (r == 9) op_code = OP_CLR;
            else             op_code = 11'($urandom);
            cycle();
            got = {minutes, seconds, hs, running, rollover, lap_valid, lap_time, lap_ovf};
            tests_run++;
            if (got !== mexp() || {minutes2, seconds2, hs2} !== mtime(m_run, DIV2)) begin
                tests_failed++;
                $display("FAIL random[%0d]: got %h/%h expected %h/%h", i, got,
                         {minutes2, seconds2, hs2}, mexp(), mtime(m_run, DIV2));
            end
        end
        go = 1'b0;
        lap_rd = 1'b0;
        op_valid = 1'b0;
        op_code = '0;
    endtask

    task automatic test_async_reset();
        op(OP_CLR);
        start_go();
        repeat (200) cycle();
        op(OP_LAP);
        repeat (219) cycle();
        tests_run++;
        if ({minutes, seconds, hs, lap_valid} !== {10'd0, 10'd0, 10'd42, LAP_EN}) begin
            tests_failed++;
            $display("FAIL pre_reset: %0d:%0d.%0d valid=%b expected 0:0.42", minutes, seconds, hs,
                     lap_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({minutes, seconds, hs, running, rollover, lap_valid, lap_time, lap_ovf} !== 64'd0 ||
            {minutes2, seconds2, hs2, running2} !== 31'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got %h expected 0",
                     {minutes, seconds, hs, running, rollover, lap_valid, lap_time, lap_ovf});
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        cycle();
        tests_run++;
        if ({minutes, seconds, hs, running, rollover, lap_valid, lap_time, lap_ovf} !== mexp()) begin
            tests_failed++;
            $display("FAIL post_reset: got %h expected %h",
                     {minutes, seconds, hs, running, rollover, lap_valid, lap_time, lap_ovf}, mexp());
        end
    endtask

    initial begin
        test_reset();
        test_go_timing();
        test_pause();
        test_lap();
        test_simultaneous();
        test_rollover();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
